// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg
//   Shared types and helpers for the ring-oscillator frequency meter.
//   - state_t    : measurement FSM states
//   - stages()   : NAND2 stage count of ring k
//   - *_DEF      : default prescaler width and settle length
`timescale 1ns/1ps
package ro_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int PRESCALE_W_DEF = 4;
  localparam int SETTLE_DEF     = 8;

  // Ring k is always odd so it oscillates when enabled.
  function automatic int stages(input int k, input int depth, input int depth_step);
    return 2 * (depth + k * depth_step) + 1;
  endfunction

endpackage

// File: rtl/nand2_ring_osc_n.sv
// nand2_ring_osc_n
//   Gated ring oscillator made of STAGES NAND2 cells (STAGES must be odd).
//   The first cell gates the loop with ena; the rest are NAND2s with one
//   input tied high, acting as inverters. With ena low the ring parks at a
//   static level.
// Ports:
//   ena      in   1  ring enable (active high)
//   osc_out  out  1  ring output
`timescale 1ns/1ps
module nand2_ring_osc_n #(
  parameter int STAGES = 41
) (
  input  logic ena,
  output logic osc_out
);

  (* keep = "true", dont_touch = "true" *) wire [STAGES-1:0] node;
  (* keep = "true", dont_touch = "true" *) wire              fb;

  assign fb = node[STAGES-1];

  (* keep = "true", dont_touch = "true" *) nand u_gate (node[0], ena, fb);

  for (genvar i = 1; i < STAGES; i++) begin : g_stage
    (* keep = "true", dont_touch = "true" *) nand u_inv (node[i], node[i-1], 1'b1);
  end

  assign osc_out = fb;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
//   Multi-channel ring-oscillator frequency meter. One ring per channel;
//   only the selected ring is enabled. Each ring clocks a free-running
//   2^PRESCALE_W divider; the selected divider MSB is synchronised into clk
//   and its rising edges are counted over a window of clk cycles.
//
//   Optional feature (macro RO_FREQ_METER_CONT_EN): adds input 'cont'.
//   While cont is high the meter re-arms itself after each window with the
//   latched channel and window; done pulses every window.
//
// Ports:
//   clk       in   1         system clock
//   rst       in   1         synchronous active-high reset
//   start     in   1         measurement request, honoured only when idle
//   cont      in   1         continuous mode (RO_FREQ_METER_CONT_EN only)
//   ch_sel    in   CH_W      channel, latched on accepted start (clamped)
//   window    in   WINDOW_W  window length in clk cycles, latched on start
//   busy      out  1         accepted start .. done
//   done      out  1         one-cycle pulse, count valid
//   count     out  COUNT_W   edges counted in the last window
//   overflow  out  1         count saturated in the last window
//   osc_mon   out  1         synchronised prescaled ring output (debug)
//
// State table:
//   ST_IDLE    | waiting for start, ring off
//   ST_SETTLE  | ring on, synchroniser and edge detector filling
//   ST_MEASURE | counting prescaled edges for 'window' cycles
//   ST_DONE    | done pulse, result valid
`timescale 1ns/1ps
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 20,
  parameter int DEPTH_STEP = 4,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int WINDOW_W   = 16,
  parameter int COUNT_W    = 16,
  parameter int SETTLE     = SETTLE_DEF,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
`ifdef RO_FREQ_METER_CONT_EN
  input  logic                cont,
`endif
  input  logic [CH_W-1:0]     ch_sel,
  input  logic [WINDOW_W-1:0] window,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow,
  output logic                osc_mon
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_W = (WINDOW_W > SET_W) ? WINDOW_W : SET_W;
  localparam logic [CH_W-1:0]    CH_MAX  = CH_W'(NUM_CH - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  state_t              state;
  logic [CH_W-1:0]     ch_lat;
  logic [CH_W-1:0]     ch_clamp;
  logic [WINDOW_W-1:0] win_lat;
  logic [TMR_W-1:0]    timer;
  logic [NUM_CH-1:0]   ring_ena;
  logic [NUM_CH-1:0]   osc_raw;
  logic [NUM_CH-1:0]   presc_msb;
  logic                sync_in;
  logic                sync_q1;
  logic                sync_q2;
  logic                sync_q3;
  logic                rise;
  logic                win_end;
  logic                cont_req;

`ifdef RO_FREQ_METER_CONT_EN
  assign cont_req = cont;
`else
  assign cont_req = 1'b0;
`endif

  // Out-of-range selections only exist when NUM_CH is not a power of two.
  if ((1 << CH_W) > NUM_CH) begin : g_clamp
    assign ch_clamp = (ch_sel > CH_MAX) ? CH_MAX : ch_sel;
  end else begin : g_noclamp
    assign ch_clamp = ch_sel;
  end

  // Rings and their free-running prescalers (no reset: initial phase is
  // absorbed by the +/-1 count tolerance).
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PRESCALE_W-1:0] div;

    nand2_ring_osc_n #(
      .STAGES (stages(k, DEPTH, DEPTH_STEP))
    ) u_ring (
      .ena     (ring_ena[k]),
      .osc_out (osc_raw[k])
    );

    always_ff @(posedge osc_raw[k]) begin
      div <= div + PRESCALE_W'(1);
    end

    assign presc_msb[k] = div[PRESCALE_W-1];
  end

  // Gating with the enable keeps the synchroniser input at 0 while idle.
  assign sync_in = presc_msb[ch_lat] & ring_ena[ch_lat];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
    end else begin
      sync_q1 <= sync_in;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign rise    = sync_q2 & ~sync_q3;
  assign osc_mon = sync_q2 & (|ring_ena);

  // Last cycle of the window (or end of settle with an empty window).
  assign win_end = (timer == '0) &&
                   ((state == ST_MEASURE) ||
                    (state == ST_SETTLE && win_lat == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      ring_ena <= '0;
      ch_lat   <= '0;
      win_lat  <= '0;
      timer    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ch_lat   <= ch_clamp;
            win_lat  <= window;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            ring_ena <= NUM_CH'(1) << ch_clamp;
            timer    <= TMR_W'(SETTLE - 1);
            state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer == '0) begin
            timer <= TMR_W'(win_lat - WINDOW_W'(1));
            state <= ST_MEASURE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            if (count == CNT_MAX) overflow <= 1'b1;
            else                  count    <= count + COUNT_W'(1);
          end
          timer <= timer - TMR_W'(1);
        end
        ST_DONE: begin
          // busy still high here means the window ended in continuous mode.
          // The DONE cycle counts as the first settle cycle so windows
          // repeat every SETTLE+window cycles.
          if (busy) begin
            count    <= '0;
            overflow <= 1'b0;
            timer    <= TMR_W'(SETTLE - 2);
            state    <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (win_end) begin
        state <= ST_DONE;
        done  <= 1'b1;
        busy  <= cont_req;
        if (!cont_req) ring_ena <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter
//   Bench for ro_freq_meter. The NAND rings are overridden with gated
//   behavioural oscillators (10/20/40/80 ns periods) forced onto each ring's
//   feedback net. Expected counts come from window time divided by the
//   prescaled oscillator period.
`timescale 1ns/1ps
module tb_ro_freq_meter;

  localparam int NUM_CH     = 4;
  localparam int WINDOW_W   = 16;
  localparam int COUNT_W    = 8;
  localparam int SETTLE     = 8;
  localparam int PRESCALE_W = 4;
  localparam int CNT_MAX    = (1 << COUNT_W) - 1;
  localparam real CLK_NS    = 20.0;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [1:0]          ch_sel = '0;
  logic [WINDOW_W-1:0] window = '0;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  count;
  logic                overflow;
  logic                osc_mon;
`ifdef RO_FREQ_METER_CONT_EN
  logic                cont = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  ro_freq_meter #(
    .NUM_CH     (NUM_CH),
    .PRESCALE_W (PRESCALE_W),
    .WINDOW_W   (WINDOW_W),
    .COUNT_W    (COUNT_W),
    .SETTLE     (SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef RO_FREQ_METER_CONT_EN
    .cont     (cont),
`endif
    .ch_sel   (ch_sel),
    .window   (window),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .overflow (overflow),
    .osc_mon  (osc_mon)
  );

  // Behavioural ring k: period 10*2^k ns, runs only while its enable is high.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_osc
    logic ph = 1'b0;
    initial begin
      force dut.g_ch[k].u_ring.fb = ph;
      #0.3;
      forever begin
        #(5.0 * (1 << k));
        ph = dut.ring_ena[k] ? ~ph : 1'b0;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got < exp - tol || got > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Prescaled rising edges expected in a window of 'win' clk cycles.
  function automatic int model_edges(input int ch, input int win);
    real t_win;
    real t_msb;
    t_win = win * CLK_NS;
    t_msb = 10.0 * (1 << ch) * (1 << PRESCALE_W);
    return $rtoi(t_win / t_msb + 0.5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int ch, input int win, input bit poke);
    int raw, exp_cnt, tol, lat, lat_exp, exp_ovf;
    raw     = model_edges(ch, win);
    exp_cnt = (raw > CNT_MAX) ? CNT_MAX : raw;
    exp_ovf = (raw > CNT_MAX + 1) ? 1 : 0;
    tol     = (win == 0 || raw > CNT_MAX + 1) ? 0 : 1;
    lat_exp = (win == 0) ? 1 + SETTLE : 1 + SETTLE + win;

    ch_sel = 2'(ch);
    window = WINDOW_W'(win);
    start  = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    check("busy_rise", busy, 1, 0);
    while (!done && lat < lat_exp + 50) begin
      if (lat == 4) check("ena_onehot", int'(dut.ring_ena), 1 << ch, 0);
      if (poke && lat == 200) begin
        ch_sel = 2'((ch + 1) % NUM_CH);
        window = WINDOW_W'(3);
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    check($sformatf("done_latency ch%0d w%0d", ch, win), lat, lat_exp, 0);
    check($sformatf("count ch%0d w%0d", ch, win), int'(count), exp_cnt, tol);
    check("overflow", int'(overflow), exp_ovf, 0);
    check("busy_at_done", busy, 0, 0);
    check("ena_off_at_done", int'(dut.ring_ena), 0, 0);
    step();
    check("done_one_cycle", done, 0, 0);
    check("count_hold", int'(count), exp_cnt, tol);
  endtask

  initial begin
    int ch, win, n;
    bit seen;

    repeat (4) step();
    rst = 1'b0;
    repeat (20) step();
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_count", int'(count), 0, 0);
    check("rst_overflow", overflow, 0, 0);
    check("rst_osc_mon", osc_mon, 0, 0);
    check("rst_ena", int'(dut.ring_ena), 0, 0);

    measure(0, 800, 1'b0);
    measure(1, 800, 1'b0);
    measure(3, 800, 1'b1);
    measure(0, 3000, 1'b0);
    measure(0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ch  = int'($urandom_range(NUM_CH - 1, 0));
      win = int'($urandom_range(1200, 0));
      measure(ch, win, 1'b0);
    end

    // Reset in the middle of a measurement.
    ch_sel = 2'd1;
    window = WINDOW_W'(800);
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (300) step();
    rst = 1'b1;
    step();
    check("mid_rst_ena", int'(dut.ring_ena), 0, 0);
    check("mid_rst_busy", busy, 0, 0);
    check("mid_rst_done", done, 0, 0);
    check("mid_rst_count", int'(count), 0, 0);
    check("mid_rst_overflow", overflow, 0, 0);
    check("mid_rst_osc_mon", osc_mon, 0, 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (900) begin
      step();
      if (done) seen = 1'b1;
    end
    check("no_done_after_rst", seen, 0, 0);

`ifdef RO_FREQ_METER_CONT_EN
    cont   = 1'b1;
    ch_sel = 2'd0;
    window = WINDOW_W'(160);
    start  = 1'b1;
    step();
    start = 1'b0;
    n     = 1;
    while (!done && n < 400) begin step(); n++; end
    check("cont_first_latency", n, 1 + SETTLE + 160, 0);
    check("cont_count0", int'(count), 20, 1);
    for (int i = 1; i < 4; i++) begin
      if (i == 3) cont = 1'b0;
      n = 0;
      do begin step(); n++; end while (!done && n < 400);
      check($sformatf("cont_period%0d", i), n, SETTLE + 160, 0);
      check($sformatf("cont_count%0d", i), int'(count), 20, 1);
      check($sformatf("cont_busy%0d", i), busy, (i == 3) ? 0 : 1, 0);
    end
    seen = 1'b0;
    repeat (300) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    check("cont_stopped", seen, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
